// File: rtl/image_loader_pkg.sv
// Shared types and constants for the ASCII octal image loader.
package image_loader_pkg;

  // Loader sequencing states.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_NUM   = 3'd1,
    S_WR_HI = 3'd2,
    S_WR_LO = 3'd3,
    S_HOLD  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // Record kind selected by the leading symbol.
  typedef enum logic [1:0] {
    REC_OFS  = 2'd0,
    REC_PC   = 2'd1,
    REC_WORD = 2'd2
  } rec_t;

  localparam logic [7:0] CH_STAR = 8'h2A;
  localparam logic [7:0] CH_AT   = 8'h40;
  localparam logic [7:0] CH_DASH = 8'h2D;
  localparam logic [7:0] CH_SP   = 8'h20;
  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_LF   = 8'h0A;
  localparam logic [7:0] CH_TAB  = 8'h09;
  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_7    = 8'h37;

  // Map a record symbol to its record kind.
  function automatic rec_t rec_of(input logic [7:0] ch);
    case (ch)
      CH_STAR: rec_of = REC_OFS;
      CH_AT:   rec_of = REC_PC;
      default: rec_of = REC_WORD;
    endcase
  endfunction

  // Saturating 8-bit increment.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/image_loader_octal_char_decode.sv
// Combinational classifier for one ASCII image byte.
module octal_char_decode
  import image_loader_pkg::*;
(
  input  logic [7:0] ch,
  output logic [2:0] digit,
  output logic       is_digit,
  output logic       is_space,
  output logic       is_symbol
);

  // Digit value is the low three bits of '0'..'7'.
  always_comb begin
    digit     = ch[2:0];
    is_digit  = (ch >= CH_0) && (ch <= CH_7);
    is_space  = (ch == CH_SP) || (ch == CH_CR) || (ch == CH_LF) || (ch == CH_TAB);
    is_symbol = (ch == CH_STAR) || (ch == CH_AT) || (ch == CH_DASH);
  end

endmodule

// File: rtl/image_loader.sv
// Parses an ASCII octal program image, writes it to program memory,
// then releases the CPU reset a fixed delay after loading completes.
module image_loader
  import image_loader_pkg::*;
#(
  parameter int unsigned RELEASE_DLY = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        char_valid,
  input  logic [7:0]  char_data,
  output logic        char_ready,
  input  logic        eof,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic [15:0] pc_start,
  output logic [15:0] pc_end,
  output logic        cpu_reset,
  output logic        load_done,
  output logic [7:0]  err_count
);

  localparam logic [31:0] DLY_LAST = 32'(RELEASE_DLY - 1);

  state_t      state;
  rec_t        rec;
  logic [15:0] acc;
  logic        have_digit;
  logic [15:0] wr_ptr;
  logic [15:0] data_offset;
  logic [15:0] init_pc;
  logic [31:0] dly_cnt;
  logic        run;

  logic [2:0]  dec_digit;
  logic        dec_is_digit;
  logic        dec_is_space;
  logic        dec_is_symbol;

  logic        accept;
  logic        commit;
  logic        reject;
  logic        idle_bad;
  logic        enter_hold;

  octal_char_decode u_decode (
    .ch        (char_data),
    .digit     (dec_digit),
    .is_digit  (dec_is_digit),
    .is_space  (dec_is_space),
    .is_symbol (dec_is_symbol)
  );

  // Handshake and per-cycle decisions; eof only acts when no byte is taken.
  always_comb begin
    char_ready = run && ((state == S_IDLE) || (state == S_NUM));
    accept     = char_valid && char_ready;
    commit     = (state == S_NUM) && have_digit &&
                 (accept ? dec_is_space : eof);
    reject     = (state == S_NUM) &&
                 (accept ? (!dec_is_digit && !(dec_is_space && have_digit))
                         : (eof && !have_digit));
    idle_bad   = (state == S_IDLE) && accept && !dec_is_symbol && !dec_is_space;
    enter_hold = !accept && eof &&
                 ((state == S_IDLE) || ((state == S_NUM) && !have_digit));
  end

  // Loader state, record accumulation, memory strobes and release timing.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      rec         <= REC_WORD;
      acc         <= '0;
      have_digit  <= 1'b0;
      wr_ptr      <= '0;
      data_offset <= '0;
      init_pc     <= '0;
      pc_start    <= '0;
      pc_end      <= '0;
      err_count   <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      load_done   <= 1'b0;
      cpu_reset   <= 1'b1;
      dly_cnt     <= '0;
      run         <= 1'b0;
    end else begin
      run      <= 1'b1;
      pc_start <= data_offset + init_pc;
      mem_we   <= 1'b0;

      if (idle_bad || reject) begin
        err_count <= sat_inc8(err_count);
      end

      if (enter_hold) begin
        state     <= S_HOLD;
        pc_end    <= wr_ptr;
        load_done <= 1'b1;
        dly_cnt   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept && dec_is_symbol) begin
              rec        <= rec_of(char_data);
              acc        <= '0;
              have_digit <= 1'b0;
              state      <= S_NUM;
            end
          end
          S_NUM: begin
            if (commit) begin
              case (rec)
                REC_OFS: begin
                  data_offset <= acc;
                  state       <= S_IDLE;
                end
                REC_PC: begin
                  init_pc <= acc;
                  state   <= S_IDLE;
                end
                default: begin
                  mem_we    <= 1'b1;
                  mem_addr  <= wr_ptr;
                  mem_wdata <= acc[15:8];
                  state     <= S_WR_HI;
                end
              endcase
            end else if (reject) begin
              state <= S_IDLE;
            end else if (accept) begin
              acc        <= {acc[12:0], dec_digit};
              have_digit <= 1'b1;
            end
          end
          S_WR_HI: begin
            mem_we    <= 1'b1;
            mem_addr  <= wr_ptr + 16'd1;
            mem_wdata <= acc[7:0];
            state     <= S_WR_LO;
          end
          S_WR_LO: begin
            wr_ptr <= wr_ptr + 16'd2;
            state  <= S_IDLE;
          end
          S_HOLD: begin
            if (dly_cnt == DLY_LAST) begin
              cpu_reset <= 1'b0;
              state     <= S_DONE;
            end else begin
              dly_cnt <= dly_cnt + 32'd1;
            end
          end
          S_DONE: begin
            state <= S_DONE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_image_loader.sv
// Self-checking bench for image_loader: directed images plus random images
// compared against a byte-stream parsing model.
module tb_image_loader;

  localparam int DLY = 5;

  typedef logic [7:0] bytes_t[$];

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        char_valid = 1'b0;
  logic [7:0]  char_data = '0;
  logic        char_ready;
  logic        eof = 1'b0;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [15:0] pc_start;
  logic [15:0] pc_end;
  logic        cpu_reset;
  logic        load_done;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

  logic [23:0] wr_q[$];
  logic [23:0] exp_q[$];
  int          exp_err;
  logic [15:0] exp_pc_start;
  logic [15:0] exp_pc_end;

  int cyc = 0;
  int t_done = -1;
  int t_rel = -1;
  int ready_bad = 0;
  int strobe_bad = 0;

  image_loader #(.RELEASE_DLY(DLY)) dut (
    .clock      (clock),
    .reset      (reset),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .eof        (eof),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .pc_start   (pc_start),
    .pc_end     (pc_end),
    .cpu_reset  (cpu_reset),
    .load_done  (load_done),
    .err_count  (err_count)
  );

  always #5 clock = ~clock;

  // Observe outputs mid-cycle: capture writes and release timing.
  always @(negedge clock) begin
    cyc++;
    if (!reset) begin
      wr_q.delete();
      t_done = -1;
      t_rel  = -1;
      if (mem_we) strobe_bad++;
    end else begin
      if (mem_we) begin
        wr_q.push_back({mem_addr, mem_wdata});
        if (char_ready) ready_bad++;
      end
      if (load_done && t_done < 0) t_done = cyc;
      if (!cpu_reset && t_rel < 0) t_rel = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_ws(input logic [7:0] c);
    return c == 8'h20 || c == 8'h0A || c == 8'h0D || c == 8'h09;
  endfunction

  function automatic bit is_oct(input logic [7:0] c);
    return c >= 8'h30 && c <= 8'h37;
  endfunction

  // Reference: scan the image as records "<sym><octal digits><whitespace|end>".
  task automatic build_expect(input bytes_t img);
    int n = img.size();
    int i = 0;
    int unsigned val;
    int nd;
    bit ok;
    logic [7:0] sym;
    logic [15:0] ofs = 16'd0;
    logic [15:0] ipc = 16'd0;
    logic [15:0] ptr = 16'd0;
    exp_q.delete();
    exp_err = 0;
    while (i < n) begin
      sym = img[i];
      i++;
      if (sym == 8'h2A || sym == 8'h40 || sym == 8'h2D) begin
        val = 0;
        nd  = 0;
        while (i < n && is_oct(img[i])) begin
          val = val * 8 + int'(img[i] - 8'h30);
          nd++;
          i++;
        end
        if (i == n) begin
          ok = (nd > 0);
        end else begin
          ok = (nd > 0) && is_ws(img[i]);
          i++;
        end
        if (!ok) begin
          exp_err++;
        end else if (sym == 8'h2A) begin
          ofs = val[15:0];
        end else if (sym == 8'h40) begin
          ipc = val[15:0];
        end else begin
          exp_q.push_back({ptr, val[15:8]});
          exp_q.push_back({ptr + 16'd1, val[7:0]});
          ptr = ptr + 16'd2;
        end
      end else if (!is_ws(sym)) begin
        exp_err++;
      end
    end
    if (exp_err > 255) exp_err = 255;
    exp_pc_start = ofs + ipc;
    exp_pc_end   = ptr;
  endtask

  function automatic bytes_t str2q(input string s);
    bytes_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic bytes_t gen_image();
    bytes_t q;
    logic [7:0] ws[4]  = '{8'h20, 8'h0A, 8'h0D, 8'h09};
    logic [7:0] bad[4] = '{8'h38, 8'h39, 8'h23, 8'h78};
    int nrec = $urandom_range(1, 6);
    int k;
    int nd;
    for (int r = 0; r < nrec; r++) begin
      if ($urandom_range(0, 7) == 0) q.push_back(bad[$urandom_range(0, 3)]);
      k = $urandom_range(0, 9);
      q.push_back(k == 0 ? 8'h2A : (k == 1 ? 8'h40 : 8'h2D));
      nd = $urandom_range(0, 7);
      for (int d = 0; d < nd; d++) q.push_back(8'h30 + 8'($urandom_range(0, 7)));
      if ($urandom_range(0, 9) == 0) q.push_back(bad[$urandom_range(0, 3)]);
      if (!(r == nrec - 1 && $urandom_range(0, 2) == 0))
        q.push_back(ws[$urandom_range(0, 3)]);
    end
    return q;
  endfunction

  task automatic reset_dut();
    @(negedge clock);
    char_valid = 1'b0;
    eof        = 1'b0;
    reset      = 1'b0;
    #2;
    check("rst_char_ready", char_ready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_load_done", load_done, 0);
    check("rst_err_count", err_count, 0);
    check("rst_pc_start", pc_start, 0);
    check("rst_pc_end", pc_end, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  // Present one byte from a negedge; returns at the negedge after acceptance.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    char_valid = 1'b1;
    char_data  = b;
    while (!char_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("byte_accept", char_ready, 1);
    @(negedge clock);
    if (gap > 0) begin
      char_valid = 1'b0;
      repeat (gap) @(negedge clock);
    end
    char_valid = 1'b0;
  endtask

  task automatic run_image(input string tag, input bytes_t img, input int gapmax, input bit do_reset);
    int n;
    if (do_reset) reset_dut();
    build_expect(img);
    foreach (img[i]) send_byte(img[i], $urandom_range(0, gapmax));
    eof = 1'b1;
    n = 0;
    while (!load_done && n < 300) begin
      @(negedge clock);
      n++;
    end
    check({tag, "/load_done"}, load_done, 1);
    n = 0;
    while (cpu_reset && n < 50) begin
      @(negedge clock);
      n++;
    end
    eof = 1'b0;
    @(negedge clock);
    check({tag, "/cpu_reset"}, cpu_reset, 0);
    check({tag, "/release_dly"}, t_rel - t_done, DLY);
    check({tag, "/char_ready_done"}, char_ready, 0);
    check({tag, "/pc_start"}, pc_start, exp_pc_start);
    check({tag, "/pc_end"}, pc_end, exp_pc_end);
    check({tag, "/err_count"}, err_count, exp_err);
    check({tag, "/n_writes"}, wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
      check($sformatf("%s/wr%0d", tag, i), wr_q[i], exp_q[i]);
  endtask

  initial begin
    bytes_t img34;
    bytes_t part;
    img34 = str2q("*000100\n@000004\n-012700\n-000001\n");

    // Back-to-back bytes through word commits, fixed expectations too.
    run_image("r034", img34, 0, 1'b1);
    check("r034_pc_start_k", pc_start, 16'h0044);
    check("r034_pc_end_k", pc_end, 16'd4);
    check("r034_wr1_k", wr_q.size() > 1 ? wr_q[1] : 24'hFFFFFF, {16'd1, 8'hC0});

    run_image("r035", str2q("#\n-000007\n"), 2, 1'b1);
    check("r035_err_k", err_count, 1);

    run_image("r036", str2q("-18\n-\n"), 1, 1'b1);
    check("r036_err_k", err_count, 2);
    check("r036_pc_end_k", pc_end, 0);

    run_image("r037", str2q("-1234567"), 1, 1'b1);
    check("r037_pc_end_k", pc_end, 2);
    check("r037_wr0_k", wr_q.size() > 0 ? wr_q[0] : 24'hFFFFFF, {16'd0, 8'h39});

    // Abort in the high-byte write, then reload the same image.
    reset_dut();
    part = str2q("*000100\n@000004\n-012700\n");
    foreach (part[i]) send_byte(part[i], 0);
    check("r039_in_wr_hi", mem_we, 1);
    #2 reset = 1'b0;
    #1;
    check("r039_mem_we", mem_we, 0);
    check("r039_cpu_reset", cpu_reset, 1);
    check("r039_load_done", load_done, 0);
    check("r039_char_ready", char_ready, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    run_image("r039_reload", img34, 0, 1'b0);
    check("r039_pc_start_k", pc_start, 16'h0044);

    for (int t = 0; t < 20; t++)
      run_image($sformatf("rnd%0d", t), gen_image(), t % 3, 1'b1);

    check("ready_during_write", ready_bad, 0);
    check("strobe_during_reset", strobe_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/image_loader.md
IMAGE_LOADER -- requirements
Module: image_loader

Interface
REQ-001 SHALL have parameter RELEASE_DLY, default 5; cycles from load_done rising to cpu_reset falling.
REQ-002 SHALL have port clock  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port char_valid  input  1  ASCII image byte available.
REQ-005 SHALL have port char_data  input  8  ASCII image byte.
REQ-006 SHALL have port char_ready  output  1  byte accepted when char_valid && char_ready.
REQ-007 SHALL have port eof  input  1  level; source holds high after last byte until load_done.
REQ-008 SHALL have port mem_we  output  1  one-cycle byte write strobe to program memory.
REQ-009 SHALL have port mem_addr  output  16  byte address of write.
REQ-010 SHALL have port mem_wdata  output  8  write byte.
REQ-011 SHALL have port pc_start  output  16  data_offset + init_pc, mod 2^16.
REQ-012 SHALL have port pc_end  output  16  byte count written (next free address).
REQ-013 SHALL have port cpu_reset  output  1  active-high reset to the ISA core.
REQ-014 SHALL have port load_done  output  1  image fully loaded.
REQ-015 SHALL have port err_count  output  8  saturating count of rejected symbols/records.

Function
REQ-016 SHALL implement states IDLE, NUM, WR_HI, WR_LO, HOLD, DONE.
REQ-017 IDLE: '*', '@', '-' SHALL latch record type, clear accumulator/digit count, go NUM; space/CR/LF/TAB dropped; any other byte SHALL increment err_count and be dropped.
REQ-018 NUM: octal digit '0'-'7' SHALL update acc = (acc<<3 | digit) truncated to 16 bits, digit count +1.
REQ-019 NUM: whitespace with digit count >= 1 SHALL commit record; with 0 digits SHALL increment err_count, discard, go IDLE.
REQ-020 NUM: any other byte (incl. '8','9') SHALL increment err_count, discard record, go IDLE.
REQ-021 Commit '*' SHALL load data_offset; '@' SHALL load init_pc; both return IDLE next cycle.
REQ-022 Commit '-' SHALL go WR_HI: mem_we=1, mem_addr=wr_ptr, mem_wdata=acc[15:8]; then WR_LO: mem_we=1, mem_addr=wr_ptr+1, mem_wdata=acc[7:0]; wr_ptr += 2 (wraps 16 bits); go IDLE.
REQ-023 char_ready SHALL be 1 only in IDLE and NUM; 0 in WR_HI, WR_LO, HOLD, DONE.
REQ-024 pc_start SHALL be registered, updated the cycle after any '*' or '@' commit.
REQ-025 eof high in IDLE with no byte accepted that cycle SHALL go HOLD; in NUM with digits >= 1 and no byte accepted SHALL commit as whitespace, then HOLD after the write; in NUM with 0 digits SHALL count error, go HOLD.
REQ-026 A byte accepted in the same cycle as eof SHALL be processed first; eof acts on a later cycle.
REQ-027 Entering HOLD SHALL set pc_end=wr_ptr and load_done=1; cpu_reset SHALL fall exactly RELEASE_DLY cycles after load_done rises, then state DONE (terminal until reset).
REQ-028 err_count SHALL saturate at 255.
REQ-029 mem_we SHALL never be high outside WR_HI/WR_LO.

Reset
REQ-030 reset low SHALL asynchronously force: state IDLE, acc/wr_ptr/data_offset/init_pc/pc_start/pc_end/err_count 0, mem_we 0, mem_addr 0, mem_wdata 0, char_ready 0 while asserted, load_done 0, cpu_reset 1.
REQ-031 Reset mid-record or mid-write SHALL abandon it; no further strobe after reset asserts.

Structure
REQ-032 State enum typedef and ASCII constants ('*','@','-', whitespace) SHALL live in the shared parameters package.
REQ-033 One combinational sub-module octal_char_decode SHALL classify a byte (digit value, is_digit, is_space, is_symbol).

Verification
REQ-034 "*000100\n@000004\n-012700\n-000001\n"+eof -> writes (0,0x15),(1,0xC0),(2,0x00),(3,0x01); pc_start=0x0044; pc_end=4; cpu_reset falls 5 cycles after load_done.
REQ-035 "#\n-000007\n" -> err_count=1; writes (0,0x00),(1,0x07) only.
REQ-036 "-18\n-\n" -> err_count=2, no mem_we, wr_ptr stays 0.
REQ-037 "-1234567" then eof (no newline) -> writes (0,0x39),(1,0x77); pc_end=2.
REQ-038 char_valid held high through a '-' commit -> char_ready low for WR_HI and WR_LO cycles, no byte lost or duplicated.
REQ-039 reset asserted during WR_HI -> mem_we low immediately, cpu_reset=1, load_done=0; reload of REQ-034 image after release reproduces identical results.
